new_usb_dmaedqueue: RTL and testbench
=====================================

# new_usb_dmaedqueue

Parametrised endpoint-descriptor output queue between the OHCI DMA read path and the TD processing stage. Assembles 128-bit EDs from DMA beats into a Depth-deep FIFO, drops skippable EDs while reporting their NextED pointer for prefetch, keeps one stash slot per list context (periodic/control/bulk/isochronous) across context switches, and presents a popped ED in a `firstin` register.

## Interface
- `DataWidth`, 32: DMA beat width; 32 or 64 only; BeatsPerEd = 128/DataWidth.
- `Depth`, 2: number of assembled ED slots; ≥1.
- `NumCtx`, 3: number of list contexts; CtxW = max(1,$clog2(NumCtx)).
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `flush_i` in 1: synchronous clear of FIFO, assembly, all stashes, firstin_valid_o.
- `ctx_switch_i` in 1: one-cycle pulse; context changes to `active_ctx_i`.
- `active_ctx_i` in CtxW: context sampled on `ctx_switch_i`.
- `dma_data_i` in DataWidth: ED beat, dword0 first, little-endian dword order within a beat.
- `dma_valid_i` in 1 / `dma_ready_o` out 1: beat handshake.
- `skip_o` out 1: one-cycle pulse, skippable ED dropped.
- `skip_next_o` out 28: NextED[31:4] of the dropped ED, valid with `skip_o`.
- `pop_i` in 1 / `pop_ready_o` out 1: ED transfer into firstin.
- `head_o` out endpoint_descriptor: current head candidate (stash or FIFO).
- `firstin_o` out endpoint_descriptor: last popped ED.
- `firstin_valid_o` out 1: firstin_o holds a popped ED.
- `count_o` out $clog2(Depth+1): occupied FIFO slots.

## Operation
- ED dwords: d0 status (MPS[26:16], F15, K14, S13, D[12:11], EN[10:7], FA[6:0]); d1 TailP[31:4]; d2 HeadP[31:4], C bit1, H bit0; d3 NextED[31:4].
- Beat counter 0..BeatsPerEd-1 fills assembly buffer; wraps to 0 after last beat.
- Skippable ED: K=1, or H=1, or TailP == HeadP. Never written to FIFO; `skip_o`/`skip_next_o` instead.
- Non-skippable ED written to FIFO tail; circular pointers, Depth entries, wrap-around.
- `dma_ready_o` = (count_o < Depth) && !ctx_switch_i && !flush_i.
- Head source priority: stash[cur_ctx] if valid, else FIFO oldest slot. `pop_ready_o` = either valid.
- Pop (pop_i && pop_ready_o): firstin_o <= head_o, firstin_valid_o <= 1, source slot freed (stash valid cleared, or FIFO read pointer advanced). pop_i with pop_ready_o=0 ignored.
- Context switch: partial assembly discarded (counter → 0). If stash[cur_ctx] invalid and FIFO non-empty (after any same-cycle pop), FIFO oldest → stash[cur_ctx]. FIFO fully emptied. cur_ctx <= active_ctx_i. Later slots are refetched via the stashed ED's NextED by the fetcher.
- Switch to same context: still flushes FIFO and stashes as above.
- Same-cycle pop + switch: pop first, then stash the next FIFO entry.
- firstin_o unaffected by switches; cleared only by flush_i/reset.
- active_ctx_i ≥ NumCtx: cur_ctx unchanged, FIFO still flushed.

## Timing
- Reset: dma_ready_o=1, pop_ready_o=0, skip_o=0, skip_next_o=0, head_o=0, firstin_o=0, firstin_valid_o=0, count_o=0, cur_ctx=0, all stashes invalid.
- Final beat accepted in cycle N: count_o increments and pop_ready_o rises in N+1, or skip_o pulses in N+1.
- Pop in cycle N: firstin_o/firstin_valid_o updated N+1; head_o shows next candidate N+1.
- Same-cycle final beat and pop with count_o=Depth impossible (ready low); with count_o<Depth both apply, count_o unchanged.
- Switch in N: stash and cur_ctx updated N+1; pop_ready_o reflects new context in N+1.
- flush_i has priority over all other inputs in the same cycle.

## Test plan
- DataWidth=32, Depth=2: push ED TailP=0x100, HeadP=0x200 (4 beats) -> pop_ready_o=1 one cycle later, count_o=1; pop -> firstin_o.headTD.address=0x20, firstin_valid_o=1.
- Push ED with TailP=HeadP=0x300, NextED=0x4000 -> skip_o one pulse, skip_next_o=0x400, count_o stays 0.
- Fill 2 EDs -> dma_ready_o=0; valid beats held until pop, then accepted, FIFO wrap order preserved across 5 EDs.
- cur_ctx=1 with 2 queued EDs, switch to 0 -> stash[1] holds first ED, count_o=0; switch back to 1 -> head_o = stashed ED, pop returns it.
- Switch after 2 of 4 beats -> partial discarded; next 4 beats form a clean ED.
- DataWidth=64, NumCtx=4: flush_i mid-assembly with stash valid -> all stashes, count_o, firstin_valid_o = 0; asynchronous rst_ni mid-burst -> reset values immediately.

Source files
------------

// File: rtl/new_usb_dmaedqueue.sv
// new_usb_dmaedqueue: OHCI endpoint-descriptor queue between DMA reads and
// TD processing, with one stash slot per list context and a firstin register.
package new_usb_dmaedqueue_pkg;

    typedef struct packed {
        logic [4:0]  rsvd;
        logic [10:0] mps;
        logic        f;
        logic        k;
        logic        s;
        logic [1:0]  d;
        logic [3:0]  en;
        logic [6:0]  fa;
    } ed_status_t;

    typedef struct packed {
        logic [27:0] address;
        logic [3:0]  rsvd;
    } ed_ptr_t;

    typedef struct packed {
        logic [27:0] address;
        logic [1:0]  rsvd;
        logic        c;
        logic        h;
    } ed_head_t;

    typedef struct packed {
        ed_ptr_t    nextED;
        ed_head_t   headTD;
        ed_ptr_t    tailTD;
        ed_status_t status;
    } endpoint_descriptor;

endpackage

module new_usb_dmaedqueue
    import new_usb_dmaedqueue_pkg::*;
#(
    parameter int  DataWidth = 32,
    parameter int  Depth     = 2,
    parameter int  NumCtx    = 3,
    localparam int CtxW      = (NumCtx > 1) ? $clog2(NumCtx) : 1,
    localparam int CntW      = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 ctx_switch_i,
    input  logic [CtxW-1:0]      active_ctx_i,
    input  logic [DataWidth-1:0] dma_data_i,
    input  logic                 dma_valid_i,
    output logic                 dma_ready_o,
    output logic                 skip_o,
    output logic [27:0]          skip_next_o,
    input  logic                 pop_i,
    output logic                 pop_ready_o,
    output endpoint_descriptor   head_o,
    output endpoint_descriptor   firstin_o,
    output logic                 firstin_valid_o,
    output logic [CntW-1:0]      count_o
);

    localparam int Beats = 128 / DataWidth;
    localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1;

    logic [DataWidth-1:0] asm_q [Beats];
    logic [BeatW-1:0]     beat_q;
    endpoint_descriptor   fifo_q [Depth];
    logic [PtrW-1:0]      rd_q, wr_q;
    logic [CntW-1:0]      cnt_q;
    endpoint_descriptor   stash_q [NumCtx];
    logic [NumCtx-1:0]    stash_vld_q;
    logic [CtxW-1:0]      ctx_q;
    endpoint_descriptor   firstin_q;
    logic                 firstin_vld_q;
    logic                 skip_q;
    logic [27:0]          skip_next_q;

    logic [127:0]         ed_bits;
    endpoint_descriptor   ed_w, head_w;
    logic                 stash_hit, fifo_ne, beat_fire, last_beat, ed_done;
    logic                 skippable, push, pop_fire, pop_fifo;
    logic                 stash_free, stash_load;
    logic [PtrW-1:0]      rd_pop;
    logic [CntW-1:0]      cnt_pop;

    function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // The final beat is taken straight from the bus so the ED completes
    // in the same cycle it is accepted.
    always_comb begin
        ed_bits = '0;
        for (int b = 0; b < Beats; b++)
            ed_bits[b*DataWidth +: DataWidth] =
                (b == Beats - 1) ? dma_data_i : asm_q[b];
    end

    assign ed_w      = endpoint_descriptor'(ed_bits);
    assign stash_hit = stash_vld_q[ctx_q];
    assign fifo_ne   = (cnt_q != '0);
    assign head_w    = stash_hit ? stash_q[ctx_q] :
                       (fifo_ne ? fifo_q[rd_q] : '0);

    assign dma_ready_o = (cnt_q < CntW'(Depth)) && !ctx_switch_i && !flush_i;
    assign beat_fire   = dma_valid_i && dma_ready_o;
    assign last_beat   = (beat_q == BeatW'(Beats - 1));
    assign ed_done     = beat_fire && last_beat;
    assign skippable   = ed_w.status.k || ed_w.headTD.h ||
                         (ed_w.tailTD.address == ed_w.headTD.address);
    assign push        = ed_done && !skippable;

    assign pop_ready_o = stash_hit || fifo_ne;
    assign pop_fire    = pop_i && pop_ready_o && !flush_i;
    assign pop_fifo    = pop_fire && !stash_hit;
    assign rd_pop      = pop_fifo ? inc(rd_q) : rd_q;
    assign cnt_pop     = cnt_q - CntW'(pop_fifo);
    // A same-cycle pop happens first, so the stash sees what remains.
    assign stash_free  = !stash_hit || pop_fire;
    assign stash_load  = ctx_switch_i && !flush_i && stash_free &&
                         (cnt_pop != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q        <= '0;
            rd_q          <= '0;
            wr_q          <= '0;
            cnt_q         <= '0;
            stash_vld_q   <= '0;
            ctx_q         <= '0;
            firstin_q     <= '0;
            firstin_vld_q <= 1'b0;
            skip_q        <= 1'b0;
            skip_next_q   <= '0;
        end else if (flush_i) begin
            beat_q        <= '0;
            rd_q          <= '0;
            wr_q          <= '0;
            cnt_q         <= '0;
            stash_vld_q   <= '0;
            firstin_q     <= '0;
            firstin_vld_q <= 1'b0;
            skip_q        <= 1'b0;
            skip_next_q   <= '0;
        end else begin
            skip_q      <= ed_done && skippable;
            skip_next_q <= (ed_done && skippable) ?
                           ed_w.nextED.address : '0;
            if (pop_fire) begin
                firstin_q     <= head_w;
                firstin_vld_q <= 1'b1;
            end
            if (pop_fire && stash_hit)
                stash_vld_q[ctx_q] <= 1'b0;
            if (stash_load)
                stash_vld_q[ctx_q] <= 1'b1;
            if (ctx_switch_i) begin
                beat_q <= '0;
                rd_q   <= '0;
                wr_q   <= '0;
                cnt_q  <= '0;
                if (int'(active_ctx_i) < NumCtx)
                    ctx_q <= active_ctx_i;
            end else begin
                if (beat_fire)
                    beat_q <= last_beat ? '0 : beat_q + BeatW'(1);
                rd_q  <= rd_pop;
                if (push)
                    wr_q <= inc(wr_q);
                cnt_q <= cnt_pop + CntW'(push);
            end
        end
    end

    // Payload storage; validity is tracked by the reset registers above.
    always_ff @(posedge clk_i) begin
        if (beat_fire && !last_beat)
            asm_q[beat_q] <= dma_data_i;
        if (push)
            fifo_q[wr_q] <= ed_w;
        if (stash_load)
            stash_q[ctx_q] <= fifo_q[rd_pop];
    end

    assign skip_o          = skip_q;
    assign skip_next_o     = skip_next_q;
    assign head_o          = head_w;
    assign firstin_o       = firstin_q;
    assign firstin_valid_o = firstin_vld_q;
    assign count_o         = cnt_q;

endmodule

// File: tb/tb_new_usb_dmaedqueue.sv
// tb_new_usb_dmaedqueue: directed vectors plus randomized traffic against
// a queue-based reference model for the ED queue.
module tb_new_usb_dmaedqueue;
    import new_usb_dmaedqueue_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst32, fl32, sw32, v32, pop32;
    logic [1:0]         act32;
    logic [31:0]        d32;
    logic               rdy32, skip32, prdy32, fv32;
    logic [27:0]        sn32;
    endpoint_descriptor head32, fi32;
    logic [1:0]         cnt32;

    logic               rst64, fl64, sw64, v64, pop64;
    logic [1:0]         act64;
    logic [63:0]        d64;
    logic               rdy64, skip64, prdy64, fv64;
    logic [27:0]        sn64;
    endpoint_descriptor head64, fi64;
    logic [1:0]         cnt64;

    new_usb_dmaedqueue #(.DataWidth(32), .Depth(2), .NumCtx(3)) u32 (
        .clk_i(clk), .rst_ni(rst32), .flush_i(fl32),
        .ctx_switch_i(sw32), .active_ctx_i(act32),
        .dma_data_i(d32), .dma_valid_i(v32), .dma_ready_o(rdy32),
        .skip_o(skip32), .skip_next_o(sn32),
        .pop_i(pop32), .pop_ready_o(prdy32),
        .head_o(head32), .firstin_o(fi32),
        .firstin_valid_o(fv32), .count_o(cnt32)
    );

    new_usb_dmaedqueue #(.DataWidth(64), .Depth(2), .NumCtx(4)) u64 (
        .clk_i(clk), .rst_ni(rst64), .flush_i(fl64),
        .ctx_switch_i(sw64), .active_ctx_i(act64),
        .dma_data_i(d64), .dma_valid_i(v64), .dma_ready_o(rdy64),
        .skip_o(skip64), .skip_next_o(sn64),
        .pop_i(pop64), .pop_ready_o(prdy64),
        .head_o(head64), .firstin_o(fi64),
        .firstin_valid_o(fv64), .count_o(cnt64)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send32(input logic [127:0] ed, input int nb);
        int b = 0;
        int guard = 0;
        while (b < nb && guard < 100) begin
            @(negedge clk);
            v32 = 1'b1;
            d32 = ed[b*32 +: 32];
            #1;
            if (rdy32) b++;
            guard++;
        end
        @(negedge clk);
        v32 = 1'b0;
        if (b < nb) chk("send32_timeout", 128'(b), 128'(nb));
    endtask

    task automatic send64(input logic [127:0] ed, input int nb);
        int b = 0;
        int guard = 0;
        while (b < nb && guard < 100) begin
            @(negedge clk);
            v64 = 1'b1;
            d64 = ed[b*64 +: 64];
            #1;
            if (rdy64) b++;
            guard++;
        end
        @(negedge clk);
        v64 = 1'b0;
        if (b < nb) chk("send64_timeout", 128'(b), 128'(nb));
    endtask

    task automatic do_pop32();
        @(negedge clk); pop32 = 1'b1;
        @(negedge clk); pop32 = 1'b0;
    endtask

    task automatic do_pop64();
        @(negedge clk); pop64 = 1'b1;
        @(negedge clk); pop64 = 1'b0;
    endtask

    task automatic do_sw32(input logic [1:0] c);
        @(negedge clk); sw32 = 1'b1; act32 = c;
        @(negedge clk); sw32 = 1'b0;
    endtask

    task automatic do_sw64(input logic [1:0] c);
        @(negedge clk); sw64 = 1'b1; act64 = c;
        @(negedge clk); sw64 = 1'b0;
    endtask

    typedef struct {
        string       nm;
        logic [31:0] d0, d1, d2, d3;
        logic        exp_skip;
        logic [27:0] exp_addr;
    } vec_t;

    // Reference model state for the randomized phase
    logic [127:0] m_fifo[$];
    logic [127:0] m_stash[3];
    bit           m_sv[3];
    int           m_cur;
    logic [31:0]  m_part[$];
    logic [127:0] m_fi;
    bit           m_fv, m_skip;
    logic [27:0]  m_sn;

    function automatic logic [127:0] m_head();
        if (m_sv[m_cur]) return m_stash[m_cur];
        if (m_fifo.size() > 0) return m_fifo[0];
        return '0;
    endfunction

    function automatic logic [127:0] gen_ed();
        logic [31:0] d0, d1, d2, d3;
        d0 = $urandom;
        d0[14] = ($urandom_range(7) == 0);
        d1 = $urandom;
        d2 = $urandom;
        d2[0] = ($urandom_range(7) == 0);
        if ($urandom_range(3) == 0) d2[31:4] = d1[31:4];
        d3 = $urandom;
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [127:0] mk(input int k);
        return {32'h3000 + 32'(k) * 32'h100, 32'h2000 + 32'(k) * 32'h10,
                32'h1000 + 32'(k) * 32'h10, 32'(k)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t         vt[7];
        logic [127:0] ed;
        logic [127:0] e5[5];

        vt[0] = '{"plain",   32'h0,         32'h100,       32'h200,
                  32'h1000,    1'b0, 28'h0000020};
        vt[1] = '{"eq_ptr",  32'h0,         32'h300,       32'h300,
                  32'h4000,    1'b1, 28'h0000400};
        vt[2] = '{"k_bit",   32'h0000_4000, 32'h100,       32'h200,
                  32'h5550,    1'b1, 28'h0000555};
        vt[3] = '{"h_bit",   32'h0,         32'h100,       32'h201,
                  32'hABCDEF00, 1'b1, 28'hABCDEF0};
        vt[4] = '{"eq_cbit", 32'h0,         32'h1230,      32'h1232,
                  32'h7770,    1'b1, 28'h0000777};
        vt[5] = '{"hi_tail", 32'h07FF_BFFF, 32'hFFFF_FFF0, 32'h0000_0012,
                  32'h0,       1'b0, 28'h0000001};
        vt[6] = '{"hi_head", 32'h0,         32'h0,         32'hFFFF_FFF0,
                  32'h10,      1'b0, 28'hFFFFFFF};
        for (int k = 0; k < 5; k++) e5[k] = mk(k);

        {rst32, fl32, sw32, v32, pop32, act32, d32} = '0;
        {rst64, fl64, sw64, v64, pop64, act64, d64} = '0;
        #3;
        chk("rst_dma_ready", rdy32, 1);
        chk("rst_pop_ready", prdy32, 0);
        chk("rst_skip", skip32, 0);
        chk("rst_skip_next", sn32, 0);
        chk("rst_head", head32, 0);
        chk("rst_firstin", fi32, 0);
        chk("rst_firstin_valid", fv32, 0);
        chk("rst_count", cnt32, 0);
        chk("rst64_count", cnt64, 0);
        chk("rst64_dma_ready", rdy64, 1);
        @(negedge clk);
        rst32 = 1'b1;
        rst64 = 1'b1;

        for (int i = 0; i < 7; i++) begin
            ed = {vt[i].d3, vt[i].d2, vt[i].d1, vt[i].d0};
            send32(ed, 4);
            chk({vt[i].nm, "_skip"}, skip32, vt[i].exp_skip);
            chk({vt[i].nm, "_count"}, cnt32, vt[i].exp_skip ? 0 : 1);
            chk({vt[i].nm, "_pop_ready"}, prdy32, !vt[i].exp_skip);
            if (vt[i].exp_skip)
                chk({vt[i].nm, "_skip_next"}, sn32, vt[i].exp_addr);
            @(negedge clk);
            chk({vt[i].nm, "_skip_pulse"}, skip32, 0);
            if (!vt[i].exp_skip) begin
                do_pop32();
                chk({vt[i].nm, "_head_addr"}, fi32.headTD.address,
                    vt[i].exp_addr);
                chk({vt[i].nm, "_firstin"}, fi32, ed);
                chk({vt[i].nm, "_firstin_valid"}, fv32, 1);
                chk({vt[i].nm, "_count_after_pop"}, cnt32, 0);
            end
        end

        // Full FIFO back-pressure and wrap order across five EDs
        send32(e5[0], 4);
        send32(e5[1], 4);
        chk("full_count2", cnt32, 2);
        fork
            send32(e5[2], 4);
            begin
                repeat (3) @(negedge clk);
                #2;
                chk("full_ready_low", rdy32, 0);
                chk("full_count_hold", cnt32, 2);
                do_pop32();
            end
        join
        chk("wrap_pop0", fi32, e5[0]);
        do_pop32();
        chk("wrap_pop1", fi32, e5[1]);
        send32(e5[3], 4);
        do_pop32();
        chk("wrap_pop2", fi32, e5[2]);
        send32(e5[4], 4);
        do_pop32();
        chk("wrap_pop3", fi32, e5[3]);
        do_pop32();
        chk("wrap_pop4", fi32, e5[4]);
        chk("wrap_empty", cnt32, 0);

        // Context stash
        do_sw32(2'd1);
        send32(e5[0], 4);
        send32(e5[1], 4);
        do_sw32(2'd0);
        chk("ctx0_count", cnt32, 0);
        chk("ctx0_pop_ready", prdy32, 0);
        chk("ctx0_head", head32, 0);
        do_sw32(2'd1);
        chk("ctx1_pop_ready", prdy32, 1);
        chk("ctx1_head_stash", head32, e5[0]);
        do_pop32();
        chk("ctx1_pop_stash", fi32, e5[0]);
        chk("ctx1_drained", prdy32, 0);

        send32(e5[0], 4);
        send32(e5[1], 4);
        @(negedge clk);
        pop32 = 1'b1; sw32 = 1'b1; act32 = 2'd2;
        @(negedge clk);
        pop32 = 1'b0; sw32 = 1'b0;
        chk("popsw_firstin", fi32, e5[0]);
        chk("popsw_count", cnt32, 0);
        chk("popsw_ctx2_ready", prdy32, 0);
        do_sw32(2'd1);
        chk("popsw_stash_next", head32, e5[1]);
        do_pop32();
        chk("popsw_pop", fi32, e5[1]);

        send32(e5[2], 4);
        do_sw32(2'd3);
        chk("oor_ctx_ready", prdy32, 1);
        chk("oor_ctx_head", head32, e5[2]);
        do_pop32();
        chk("oor_pop", fi32, e5[2]);

        send32(e5[3], 2);
        do_sw32(2'd1);
        send32(e5[4], 4);
        chk("partial_count", cnt32, 1);
        do_pop32();
        chk("partial_clean", fi32, e5[4]);

        // 64-bit beats: flush and asynchronous reset
        send64(e5[0], 2);
        chk("w64_count", cnt64, 1);
        do_sw64(2'd2);
        chk("w64_sw_count", cnt64, 0);
        chk("w64_sw_ready", prdy64, 0);
        send64(e5[1], 2);
        do_pop64();
        chk("w64_pop", fi64, e5[1]);
        send64(e5[2], 2);
        send64(e5[3], 1);
        @(negedge clk);
        fl64 = 1'b1; v64 = 1'b1; d64 = e5[3][127:64];
        pop64 = 1'b1; sw64 = 1'b1; act64 = 2'd0;
        #1;
        chk("flush_dma_ready", rdy64, 0);
        @(negedge clk);
        {fl64, v64, pop64, sw64} = '0;
        chk("flush_count", cnt64, 0);
        chk("flush_fv", fv64, 0);
        chk("flush_firstin", fi64, 0);
        chk("flush_pop_ready", prdy64, 0);
        do_sw64(2'd0);
        chk("flush_stash_gone", prdy64, 0);
        chk("flush_head", head64, 0);
        send64(e5[4], 2);
        do_pop64();
        chk("flush_clean_ed", fi64, e5[4]);

        send64(e5[0], 2);
        do_pop64();
        send64(e5[1], 2);
        chk("prerst_count", cnt64, 1);
        @(negedge clk);
        v64 = 1'b1; d64 = e5[2][63:0];
        #2;
        rst64 = 1'b0;
        #1;
        chk("arst_count", cnt64, 0);
        chk("arst_fv", fv64, 0);
        chk("arst_firstin", fi64, 0);
        chk("arst_pop_ready", prdy64, 0);
        chk("arst_head", head64, 0);
        chk("arst_dma_ready", rdy64, 1);
        @(negedge clk);
        v64 = 1'b0;
        rst64 = 1'b1;
        send64(e5[3], 2);
        do_pop64();
        chk("arst_clean_ed", fi64, e5[3]);

        // Randomized traffic against the reference model
        @(negedge clk); rst32 = 1'b0;
        @(negedge clk); rst32 = 1'b1;
        m_fifo.delete(); m_part.delete();
        for (int c = 0; c < 3; c++) m_sv[c] = 0;
        m_cur = 0; m_fi = '0; m_fv = 0;
        ed = gen_ed();
        begin
            int idx = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                bit f, s, p, v, acc, pf, mr;
                int a;
                logic [127:0] e;
                @(negedge clk);
                f = ($urandom_range(99) == 0);
                s = ($urandom_range(24) == 0);
                a = $urandom_range(3);
                p = ($urandom_range(2) == 0);
                v = ($urandom_range(3) != 0);
                fl32 = f; sw32 = s; act32 = a[1:0];
                pop32 = p; v32 = v; d32 = ed[idx*32 +: 32];
                #1;
                mr = (m_fifo.size() < 2) && !s && !f;
                chk("rnd_dma_ready", rdy32, mr);
                chk("rnd_pop_ready", prdy32,
                    m_sv[m_cur] || m_fifo.size() > 0);
                chk("rnd_head", head32, m_head());
                acc = v && mr;
                m_skip = 0;
                m_sn = '0;
                if (f) begin
                    m_fifo.delete(); m_part.delete();
                    for (int c = 0; c < 3; c++) m_sv[c] = 0;
                    m_fi = '0; m_fv = 0;
                end else begin
                    pf = p && (m_sv[m_cur] || m_fifo.size() > 0);
                    if (pf) begin
                        m_fi = m_head();
                        m_fv = 1;
                        if (m_sv[m_cur]) m_sv[m_cur] = 0;
                        else void'(m_fifo.pop_front());
                    end
                    if (acc) begin
                        m_part.push_back(d32);
                        if (m_part.size() == 4) begin
                            e = {m_part[3], m_part[2], m_part[1], m_part[0]};
                            m_part.delete();
                            if (e[14] || e[64] || e[63:36] == e[95:68]) begin
                                m_skip = 1;
                                m_sn = e[127:100];
                            end else begin
                                m_fifo.push_back(e);
                            end
                        end
                    end
                    if (s) begin
                        m_part.delete();
                        if (!m_sv[m_cur] && m_fifo.size() > 0) begin
                            m_stash[m_cur] = m_fifo[0];
                            m_sv[m_cur] = 1;
                        end
                        m_fifo.delete();
                        if (a < 3) m_cur = a;
                    end
                end
                if (f || s) begin
                    ed = gen_ed();
                    idx = 0;
                end else if (acc) begin
                    idx++;
                    if (idx == 4) begin
                        idx = 0;
                        ed = gen_ed();
                    end
                end
                @(posedge clk);
                #1;
                chk("rnd_count", cnt32, 128'(m_fifo.size()));
                chk("rnd_skip", skip32, m_skip);
                if (m_skip) chk("rnd_skip_next", sn32, m_sn);
                chk("rnd_firstin", fi32, m_fi);
                chk("rnd_firstin_valid", fv32, m_fv);
            end
        end
        @(negedge clk);
        {fl32, sw32, v32, pop32} = '0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
